// File: rtl/if_id_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_id_fetch_queue_pkg
// Shared pipeline definitions for the IF/ID fetch queue:
//   FQ_XLEN      - datapath width the beat struct is built for
//   INST_NOP     - canonical NOP (addi x0,x0,0) shown to ID when the queue is empty
//   fq_state_e   - freeze / pending-flush FSM states
//   fetch_beat_t - one fetched {pc, insn} beat as held in the queue storage
// -----------------------------------------------------------------------------
package if_id_fetch_queue_pkg;

   localparam int unsigned FQ_XLEN = 32;

   localparam logic [FQ_XLEN-1:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      HOLD       = 2'd1,
      HOLD_FLUSH = 2'd2
   } fq_state_e;

   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_XLEN-1:0] insn;
   } fetch_beat_t;

endpackage

// File: rtl/if_id_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_id_fetch_queue_if
// Groups the two handshakes around the fetch queue.
//   Fetch side : if_valid_i, if_pc_i, if_insn_i  -> queue ; if_ready_o <- queue
//   Decode side: id_valid_o, id_pc_o, id_insn_o <- queue ; id_ready_i -> queue
// Handshake rule (both sides): a beat transfers on a rising clk edge where the
// producer's valid and the consumer's ready are both high; valid must not
// depend combinationally on ready.
// Modports: slave = the queue, master = the environment (fetch unit + decode).
// -----------------------------------------------------------------------------
interface if_id_fetch_queue_if
   import if_id_fetch_queue_pkg::*;
#(
   parameter int unsigned XLEN = FQ_XLEN
);
   logic            if_valid_i;
   logic [XLEN-1:0] if_pc_i;
   logic [XLEN-1:0] if_insn_i;
   logic            if_ready_o;
   logic            id_valid_o;
   logic [XLEN-1:0] id_pc_o;
   logic [XLEN-1:0] id_insn_o;
   logic            id_ready_i;

   modport slave (
      input  if_valid_i, if_pc_i, if_insn_i, id_ready_i,
      output if_ready_o, id_valid_o, id_pc_o, id_insn_o
   );

   modport master (
      output if_valid_i, if_pc_i, if_insn_i, id_ready_i,
      input  if_ready_o, id_valid_o, id_pc_o, id_insn_o
   );
endinterface

// File: rtl/if_id_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_id_fetch_queue
// DEPTH-entry instruction buffer between IF and ID. Accepts {pc, insn} beats
// from fetch and presents the oldest to decode. A flush (ID or EX redirect)
// empties the queue; a flush raised during the bus freeze (hold_i) is latched
// and applied on the first unfrozen cycle.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   hold_i              global freeze: no push, pop or flush takes effect
//   id_flush_i          ID-stage redirect, empties the queue
//   ex_flush_i          EX-stage redirect, empties the queue
//   fq                  fetch/decode handshakes (slave modport)
//   count_o             occupancy, 0..DEPTH
//   flush_pending_o     a flush is latched and waiting for hold_i to drop
//   state_o             FSM state, for debug/observation
// -----------------------------------------------------------------------------
module if_id_fetch_queue
   import if_id_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = FQ_XLEN
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       hold_i,
   input  logic                       id_flush_i,
   input  logic                       ex_flush_i,
   if_id_fetch_queue_if.slave         fq,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       flush_pending_o,
   output fq_state_e                  state_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   // Storage is built from the package beat struct, so the width is fixed to it.
   if (XLEN != FQ_XLEN) begin : g_xlen_check
      $error("if_id_fetch_queue: XLEN must equal FQ_XLEN");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("if_id_fetch_queue: DEPTH must be a power of two >= 2");
   end

   fq_state_e   state_q, state_d;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   fetch_beat_t mem [DEPTH];

   logic any_flush;
   logic flush_eff;
   logic full;
   logic push;
   logic pop;

   // EX outranks ID, but both have the same effect on the queue (empty it),
   // so they are simply merged here.
   assign any_flush = id_flush_i | ex_flush_i;
   assign full      = (count_q == CW'(DEPTH));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= RUN;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      flush_eff = 1'b0;
      unique case (state_q)
         RUN: begin
            if (hold_i) state_d = any_flush ? HOLD_FLUSH : HOLD;
            else        flush_eff = any_flush;
         end
         HOLD: begin
            if (hold_i) begin
               if (any_flush) state_d = HOLD_FLUSH;
            end else begin
               // Freeze ends; a flush arriving on this same cycle applies now.
               state_d   = RUN;
               flush_eff = any_flush;
            end
         end
         HOLD_FLUSH: begin
            // Further flushes are absorbed; the latched one fires on release.
            if (!hold_i) begin
               state_d   = RUN;
               flush_eff = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // ---------------------------------------------------------- handshakes
   // Ready ignores id_ready_i: a full queue refuses a beat even when it pops.
   assign fq.if_ready_o = !full && !hold_i && (state_q == RUN);
   assign fq.id_valid_o = (count_q != '0);

   assign push = fq.if_valid_i && fq.if_ready_o && !flush_eff;
   assign pop  = fq.id_valid_o && fq.id_ready_i && !hold_i && !flush_eff
                 && (state_q == RUN);

   // ------------------------------------------------- pointers / occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_eff) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   // Storage needs no reset: entries are only visible when counted.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= '{pc: fq.if_pc_i, insn: fq.if_insn_i};
   end

   // ------------------------------------------------------------- outputs
   assign fq.id_pc_o      = fq.id_valid_o ? mem[rd_ptr_q].pc   : '0;
   assign fq.id_insn_o    = fq.id_valid_o ? mem[rd_ptr_q].insn : INST_NOP;
   assign count_o         = count_q;
   assign flush_pending_o = (state_q == HOLD_FLUSH);
   assign state_o         = state_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_id_fetch_queue
// Directed bench for if_id_fetch_queue (DEPTH=4, XLEN=32). Inputs change and
// outputs are sampled 1 ns after the rising edge. Fetched instruction words
// are tagged as 0x0100_0000 | pc so the head insn can be predicted.
// -----------------------------------------------------------------------------
module tb_if_id_fetch_queue;
   import if_id_fetch_queue_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] TAG   = 32'h0100_0000;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       hold_i;
   logic       id_flush_i;
   logic       ex_flush_i;
   logic [2:0] count_o;
   logic       flush_pending_o;
   fq_state_e  state_o;

   int errors = 0;
   int checks = 0;

   if_id_fetch_queue_if #(.XLEN(32)) fq ();

   if_id_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .hold_i          (hold_i),
      .id_flush_i      (id_flush_i),
      .ex_flush_i      (ex_flush_i),
      .fq              (fq),
      .count_o         (count_o),
      .flush_pending_o (flush_pending_o),
      .state_o         (state_o)
   );

   // ------------------------------------------------- clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      hold_i        = 1'b0;
      id_flush_i    = 1'b0;
      ex_flush_i    = 1'b0;
      fq.if_valid_i = 1'b0;
      fq.if_pc_i    = '0;
      fq.if_insn_i  = '0;
      fq.id_ready_i = 1'b0;
   endtask

   task automatic push(input logic [31:0] pc);
      fq.if_valid_i = 1'b1;
      fq.if_pc_i    = pc;
      fq.if_insn_i  = TAG | pc;
      tick();
      fq.if_valid_i = 1'b0;
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
      checks++; if (fq.id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", fq.id_valid_o); end
      checks++; if (fq.id_pc_o !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", fq.id_pc_o); end
      checks++; if (fq.id_insn_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_id_insn: got %h want 00000013", fq.id_insn_o); end
      checks++; if (fq.if_ready_o !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b want 1", fq.if_ready_o); end
      checks++; if (flush_pending_o !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", flush_pending_o); end
      checks++; if (state_o !== RUN) begin errors++; $display("FAIL reset_state: got %0d want RUN", state_o); end
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      fq.id_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(32'(i * 4));
         checks++; if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count_o, i + 1); end
      end
      checks++; if (fq.if_ready_o !== 1'b0) begin errors++; $display("FAIL full_if_ready: got %b want 0", fq.if_ready_o); end
      checks++; if (fq.id_pc_o !== 32'h0) begin errors++; $display("FAIL full_head_pc: got %h want 0", fq.id_pc_o); end
      checks++; if (fq.id_insn_o !== (TAG | 32'h0)) begin errors++; $display("FAIL full_head_insn: got %h want %h", fq.id_insn_o, TAG); end
      // Fifth beat must be refused.
      push(32'h10);
      checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL overfill_count: got %0d want 4", count_o); end
      checks++; if (fq.id_pc_o !== 32'h0) begin errors++; $display("FAIL overfill_head_pc: got %h want 0", fq.id_pc_o); end
   endtask

   task automatic test_drain_wrap();
      logic [31:0] exp_pc [5];
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      // Cycle 0 is full, so 0x10 is refused; cycle 1 accepts it into slot 0.
      for (int i = 0; i < 5; i++) begin
         checks++; if (fq.id_pc_o !== exp_pc[i]) begin errors++; $display("FAIL drain_pc[%0d]: got %h want %h", i, fq.id_pc_o, exp_pc[i]); end
         fq.id_ready_i = 1'b1;
         fq.if_valid_i = (i < 2);
         fq.if_pc_i    = 32'h10;
         fq.if_insn_i  = TAG | 32'h10;
         tick();
      end
      idle_inputs();
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count_o); end
      checks++; if (fq.id_valid_o !== 1'b0) begin errors++; $display("FAIL drain_id_valid: got %b want 0", fq.id_valid_o); end
   endtask

   task automatic test_ex_flush();
      push(32'h20); push(32'h24); push(32'h28);
      checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL preflush_count: got %0d want 3", count_o); end
      ex_flush_i    = 1'b1;
      fq.if_valid_i = 1'b1;
      fq.if_pc_i    = 32'h100;
      fq.if_insn_i  = TAG | 32'h100;
      tick();
      idle_inputs();
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL exflush_count: got %0d want 0", count_o); end
      checks++; if (fq.id_valid_o !== 1'b0) begin errors++; $display("FAIL exflush_id_valid: got %b want 0", fq.id_valid_o); end
      checks++; if (fq.id_insn_o !== 32'h0000_0013) begin errors++; $display("FAIL exflush_id_insn: got %h want 00000013", fq.id_insn_o); end
      checks++; if (fq.id_pc_o !== 32'h0) begin errors++; $display("FAIL exflush_id_pc: got %h want 0", fq.id_pc_o); end
      tick();
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL exflush_dropped_push: got %0d want 0", count_o); end
      // ID-stage flush in RUN also empties at the same edge.
      push(32'h30);
      id_flush_i = 1'b1;
      tick();
      id_flush_i = 1'b0;
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL idflush_count: got %0d want 0", count_o); end
   endtask

   task automatic test_hold_flush();
      push(32'h40); push(32'h44);
      // Offer a push and a pop throughout the freeze; neither may happen.
      fq.id_ready_i = 1'b1;
      fq.if_valid_i = 1'b1;
      fq.if_pc_i    = 32'h48;
      fq.if_insn_i  = TAG | 32'h48;
      for (int c = 1; c <= 5; c++) begin
         hold_i     = 1'b1;
         id_flush_i = (c == 2);
         tick();
         checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL hold_count[%0d]: got %0d want 2", c, count_o); end
         checks++; if (fq.id_pc_o !== 32'h40) begin errors++; $display("FAIL hold_head_pc[%0d]: got %h want 40", c, fq.id_pc_o); end
         checks++; if (flush_pending_o !== (c >= 2)) begin errors++; $display("FAIL hold_pending[%0d]: got %b want %b", c, flush_pending_o, c >= 2); end
      end
      hold_i     = 1'b0;
      id_flush_i = 1'b0;
      #1;
      checks++; if (fq.if_ready_o !== 1'b0) begin errors++; $display("FAIL release_if_ready: got %b want 0", fq.if_ready_o); end
      tick();
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL release_count: got %0d want 0", count_o); end
      checks++; if (flush_pending_o !== 1'b0) begin errors++; $display("FAIL release_pending: got %b want 0", flush_pending_o); end
      checks++; if (state_o !== RUN) begin errors++; $display("FAIL release_state: got %0d want RUN", state_o); end
      // Back in RUN and empty: the still-offered beat is accepted.
      tick();
      idle_inputs();
      checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL resume_count: got %0d want 1", count_o); end
      checks++; if (fq.id_pc_o !== 32'h48) begin errors++; $display("FAIL resume_head_pc: got %h want 48", fq.id_pc_o); end
      ex_flush_i = 1'b1;
      tick();
      ex_flush_i = 1'b0;
   endtask

   task automatic test_async_reset();
      push(32'h60); push(32'h64);
      hold_i     = 1'b1;
      id_flush_i = 1'b1;
      tick();
      id_flush_i = 1'b0;
      checks++; if (flush_pending_o !== 1'b1) begin errors++; $display("FAIL prereset_pending: got %b want 1", flush_pending_o); end
      checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL prereset_count: got %0d want 2", count_o); end
      #2;
      rst_ni = 1'b0;
      #1;
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", count_o); end
      checks++; if (fq.id_valid_o !== 1'b0) begin errors++; $display("FAIL areset_id_valid: got %b want 0", fq.id_valid_o); end
      checks++; if (fq.id_pc_o !== 32'h0) begin errors++; $display("FAIL areset_id_pc: got %h want 0", fq.id_pc_o); end
      checks++; if (fq.id_insn_o !== 32'h0000_0013) begin errors++; $display("FAIL areset_id_insn: got %h want 00000013", fq.id_insn_o); end
      checks++; if (flush_pending_o !== 1'b0) begin errors++; $display("FAIL areset_pending: got %b want 0", flush_pending_o); end
      checks++; if (state_o !== RUN) begin errors++; $display("FAIL areset_state: got %0d want RUN", state_o); end
      hold_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      #1;
      checks++; if (state_o !== RUN) begin errors++; $display("FAIL postreset_state: got %0d want RUN", state_o); end
      checks++; if (fq.if_ready_o !== 1'b1) begin errors++; $display("FAIL postreset_if_ready: got %b want 1", fq.if_ready_o); end
      push(32'h70);
      checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL postreset_count: got %0d want 1", count_o); end
      checks++; if (fq.id_pc_o !== 32'h70) begin errors++; $display("FAIL postreset_head_pc: got %h want 70", fq.id_pc_o); end
   endtask

   // ---------------------------------------------------------- sequence
   initial begin
      test_reset();
      test_fill();
      test_drain_wrap();
      test_ex_flush();
      test_hold_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
